pipeline_hazard_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline (IF, ID, then PIPE_DEPTH post-decode stages; default EX, MW, WB).
- Keeps a shift-register scoreboard of in-flight destination registers.
- Drives load-use stalls, branch/jump flushes and per-operand forwarding selects, closing the data and control hazards the bare 5-stage pipeline leaves open.

---
 rtl/pipeline_hazard_unit_if.sv | 49 ++++
 rtl/pipeline_hazard_unit.sv | 162 ++++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_unit_if
// Description : ID-stage operand/destination info, EX redirect and the
//               resulting stall/flush/forwarding controls exchanged between
//               the pipeline datapath and the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PIPE_DEPTH = 3,
    parameter int FWD_W      = $clog2(PIPE_DEPTH + 1)
);
    // ID-stage instruction description
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_is_load;
    // EX-stage control-flow resolution
    logic                  ex_redirect;
    // Hazard controls back to the pipeline
    logic                  pc_hold;
    logic                  if_id_hold;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    logic [FWD_W-1:0]      fwd_sel_rs1;
    logic [FWD_W-1:0]      fwd_sel_rs2;

    // Pipeline datapath side
    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_reg_write, id_is_load, ex_redirect,
        input  pc_hold, if_id_hold, if_id_flush, id_ex_bubble,
               fwd_sel_rs1, fwd_sel_rs2
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_reg_write, id_is_load, ex_redirect,
        output pc_hold, if_id_hold, if_id_flush, id_ex_bubble,
               fwd_sel_rs1, fwd_sel_rs2
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_unit
// Description : Hazard and forwarding controller for an in-order pipeline.
//               A shift-register scoreboard tracks the destination of every
//               instruction past ID (entry 0 = EX ... entry PIPE_DEPTH-1 =
//               WB). From it the unit derives load-use stalls, redirect
//               flushes and per-operand forwarding selects, all
//               combinationally in the same cycle.
//               Optional macro HAZARD_PERF_EN adds saturating stall/flush
//               event counters with a synchronous clear (perf_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int PIPE_DEPTH   = 3,
    parameter int LOAD_LATENCY = 1,
    parameter int FWD_W        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
`ifdef HAZARD_PERF_EN
    input  logic                  perf_clr,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events,
`endif
    pipeline_hazard_unit_if.slave hz
);

    // One scoreboard slot per post-decode stage
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } sb_entry_t;

    sb_entry_t             r_sb [PIPE_DEPTH];
    sb_entry_t             w_new;

    logic [PIPE_DEPTH-1:0] w_hit_rs1;
    logic [PIPE_DEPTH-1:0] w_hit_rs2;
    logic [PIPE_DEPTH-1:0] w_young_load;
    logic [PIPE_DEPTH-1:0] w_fwd_rs1;
    logic [PIPE_DEPTH-1:0] w_fwd_rs2;
    logic                  w_load_hazard;
    logic                  w_redirect;
    logic                  w_stall;
    logic                  w_bubble;
    logic [FWD_W-1:0]      w_sel_rs1;
    logic [FWD_W-1:0]      w_sel_rs2;

    // Redirect is masked while in reset so that every output reads 0 then.
    assign w_redirect = hz.ex_redirect & resetn;

    // Per-entry source matching. x0 never matches, an unused operand never
    // matches and an empty ID slot produces no matches at all.
    generate
        for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_match
            localparam logic c_is_young = (k < LOAD_LATENCY);

            assign w_hit_rs1[k] = hz.id_valid & hz.id_uses_rs1
                                & (hz.id_rs1 != '0)
                                & r_sb[k].valid & r_sb[k].reg_write
                                & (r_sb[k].rd == hz.id_rs1);
            assign w_hit_rs2[k] = hz.id_valid & hz.id_uses_rs2
                                & (hz.id_rs2 != '0)
                                & r_sb[k].valid & r_sb[k].reg_write
                                & (r_sb[k].rd == hz.id_rs2);

            // Load data is still in flight in the youngest LOAD_LATENCY slots
            assign w_young_load[k] = c_is_young & r_sb[k].is_load;

            assign w_fwd_rs1[k] = w_hit_rs1[k] & ~w_young_load[k];
            assign w_fwd_rs2[k] = w_hit_rs2[k] & ~w_young_load[k];
        end
    endgenerate

    assign w_load_hazard = |(w_young_load & (w_hit_rs1 | w_hit_rs2));

    // A redirect squashes the ID instruction, so its hazard must not hold
    // the front end; the new target has to load.
    assign w_stall  = w_load_hazard & ~w_redirect;
    assign w_bubble = w_load_hazard | w_redirect;

    // Youngest-wins priority encode: scan oldest to youngest so the lowest
    // matching index is the last one written.
    always_comb begin
        w_sel_rs1 = '0;
        w_sel_rs2 = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (w_fwd_rs1[k]) begin
                w_sel_rs1 = FWD_W'(k + 1);
            end
            if (w_fwd_rs2[k]) begin
                w_sel_rs2 = FWD_W'(k + 1);
            end
        end
    end

    assign hz.pc_hold      = w_stall;
    assign hz.if_id_hold   = w_stall;
    assign hz.if_id_flush  = w_redirect;
    assign hz.id_ex_bubble = w_bubble;
    assign hz.fwd_sel_rs1  = w_sel_rs1;
    assign hz.fwd_sel_rs2  = w_sel_rs2;

    // Entry written into EX: a bubble when stalling/flushing, else ID fields
    always_comb begin
        w_new = '0;
        if (!w_bubble) begin
            w_new.valid     = hz.id_valid;
            w_new.rd        = hz.id_rd;
            w_new.reg_write = hz.id_reg_write;
            w_new.is_load   = hz.id_is_load;
        end
    end

    // Scoreboard shift register, one slot per stage per clock
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            r_sb[0] <= w_new;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [31:0] c_cnt_max = 32'hFFFF_FFFF;

    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    // Saturating event counters; a clear beats a same-cycle increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else if (perf_clr) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != c_cnt_max)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_redirect && (r_flush_events != c_cnt_max)) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_unit
// Description : Self-checking bench for pipeline_hazard_unit. Two instances
//               (LOAD_LATENCY 1 and 2) share the stimulus; an in-bench
//               history of issued instructions predicts every output.
//               Counter checks are compiled in with HAZARD_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_unit;
    localparam int RAW = 5;
    localparam int PD  = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_unit_if #(.REG_ADDR_W(RAW), .PIPE_DEPTH(PD)) bus1 ();
    pipeline_hazard_unit_if #(.REG_ADDR_W(RAW), .PIPE_DEPTH(PD)) bus2 ();

`ifdef HAZARD_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] sc1, fe1, sc2, fe2;
    logic [31:0] m_sc1, m_fe1, m_sc2, m_fe2;
`endif

    pipeline_hazard_unit #(.REG_ADDR_W(RAW), .PIPE_DEPTH(PD), .LOAD_LATENCY(1)) u_dut1 (
        .clk          (clk),
        .resetn       (resetn),
`ifdef HAZARD_PERF_EN
        .perf_clr     (perf_clr),
        .stall_cycles (sc1),
        .flush_events (fe1),
`endif
        .hz           (bus1.slave)
    );

    pipeline_hazard_unit #(.REG_ADDR_W(RAW), .PIPE_DEPTH(PD), .LOAD_LATENCY(2)) u_dut2 (
        .clk          (clk),
        .resetn       (resetn),
`ifdef HAZARD_PERF_EN
        .perf_clr     (perf_clr),
        .stall_cycles (sc2),
        .flush_events (fe2),
`endif
        .hz           (bus2.slave)
    );

    // Instruction as seen by the reference: what entered EX n cycles ago
    typedef struct packed {
        logic           valid;
        logic [RAW-1:0] rd;
        logic           rw;
        logic           ld;
    } inst_t;

    typedef struct packed {
        logic       pc_hold;
        logic       if_id_hold;
        logic       flush;
        logic       bubble;
        logic [1:0] sel1;
        logic [1:0] sel2;
    } exp_t;

    inst_t [PD-1:0] h1, h2;   // index = age in cycles since entering EX
    int vectors     = 0;
    int miscompares = 0;

    logic           v_rstn, v_valid, v_u1, v_u2, v_rw, v_ld, v_redir, v_clr;
    logic [RAW-1:0] v_rs1, v_rs2, v_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic reads(input logic [RAW-1:0] r);
        return v_valid && (r != 0) && ((v_u1 && v_rs1 == r) || (v_u2 && v_rs2 == r));
    endfunction

    function automatic logic [1:0] pick(input inst_t [PD-1:0] h, input int ll,
                                        input logic [RAW-1:0] src, input logic use_it);
        for (int age = 0; age < PD; age++) begin
            if (v_valid && use_it && src != 0 && h[age].valid && h[age].rw &&
                h[age].rd == src && !(h[age].ld && age < ll))
                return 2'(age + 1);
        end
        return 2'd0;
    endfunction

    function automatic exp_t predict(input inst_t [PD-1:0] h, input int ll);
        exp_t e;
        logic lh = 1'b0;
        logic rd = v_rstn && v_redir;
        for (int age = 0; age < ll; age++)
            if (h[age].valid && h[age].rw && h[age].ld && reads(h[age].rd)) lh = 1'b1;
        lh           = lh && v_rstn;
        e.pc_hold    = lh && !rd;
        e.if_id_hold = lh && !rd;
        e.flush      = rd;
        e.bubble     = lh || rd;
        e.sel1       = v_rstn ? pick(h, ll, v_rs1, v_u1) : 2'd0;
        e.sel2       = v_rstn ? pick(h, ll, v_rs2, v_u2) : 2'd0;
        return e;
    endfunction

    task automatic drive();
        resetn            = v_rstn;
        bus1.id_valid     = v_valid;  bus2.id_valid     = v_valid;
        bus1.id_rs1       = v_rs1;    bus2.id_rs1       = v_rs1;
        bus1.id_rs2       = v_rs2;    bus2.id_rs2       = v_rs2;
        bus1.id_uses_rs1  = v_u1;     bus2.id_uses_rs1  = v_u1;
        bus1.id_uses_rs2  = v_u2;     bus2.id_uses_rs2  = v_u2;
        bus1.id_rd        = v_rd;     bus2.id_rd        = v_rd;
        bus1.id_reg_write = v_rw;     bus2.id_reg_write = v_rw;
        bus1.id_is_load   = v_ld;     bus2.id_is_load   = v_ld;
        bus1.ex_redirect  = v_redir;  bus2.ex_redirect  = v_redir;
`ifdef HAZARD_PERF_EN
        perf_clr          = v_clr;
`endif
    endtask

    task automatic check_all();
        exp_t e1 = predict(h1, 1);
        exp_t e2 = predict(h2, 2);
        chk("ll1.pc_hold",      32'(bus1.pc_hold),      32'(e1.pc_hold));
        chk("ll1.if_id_hold",   32'(bus1.if_id_hold),   32'(e1.if_id_hold));
        chk("ll1.if_id_flush",  32'(bus1.if_id_flush),  32'(e1.flush));
        chk("ll1.id_ex_bubble", 32'(bus1.id_ex_bubble), 32'(e1.bubble));
        chk("ll1.fwd_sel_rs1",  32'(bus1.fwd_sel_rs1),  32'(e1.sel1));
        chk("ll1.fwd_sel_rs2",  32'(bus1.fwd_sel_rs2),  32'(e1.sel2));
        chk("ll2.pc_hold",      32'(bus2.pc_hold),      32'(e2.pc_hold));
        chk("ll2.if_id_hold",   32'(bus2.if_id_hold),   32'(e2.if_id_hold));
        chk("ll2.if_id_flush",  32'(bus2.if_id_flush),  32'(e2.flush));
        chk("ll2.id_ex_bubble", 32'(bus2.id_ex_bubble), 32'(e2.bubble));
        chk("ll2.fwd_sel_rs1",  32'(bus2.fwd_sel_rs1),  32'(e2.sel1));
        chk("ll2.fwd_sel_rs2",  32'(bus2.fwd_sel_rs2),  32'(e2.sel2));
`ifdef HAZARD_PERF_EN
        chk("ll1.stall_cycles", sc1, m_sc1);
        chk("ll1.flush_events", fe1, m_fe1);
        chk("ll2.stall_cycles", sc2, m_sc2);
        chk("ll2.flush_events", fe2, m_fe2);
`endif
    endtask

    // Reference update for the coming clock edge
    task automatic advance_model();
        exp_t  e1 = predict(h1, 1);
        exp_t  e2 = predict(h2, 2);
        inst_t n  = '{valid: v_valid, rd: v_rd, rw: v_rw, ld: v_ld};
`ifdef HAZARD_PERF_EN
        if (!v_rstn || v_clr) begin
            m_sc1 = 0; m_fe1 = 0; m_sc2 = 0; m_fe2 = 0;
        end else begin
            if (e1.pc_hold && m_sc1 != 32'hFFFF_FFFF) m_sc1++;
            if (e2.pc_hold && m_sc2 != 32'hFFFF_FFFF) m_sc2++;
            if (e1.flush   && m_fe1 != 32'hFFFF_FFFF) m_fe1++;
            if (e2.flush   && m_fe2 != 32'hFFFF_FFFF) m_fe2++;
        end
`endif
        if (!v_rstn) begin
            h1 = '0;
            h2 = '0;
        end else begin
            h1 = {h1[PD-2:0], e1.bubble ? inst_t'(0) : n};
            h2 = {h2[PD-2:0], e2.bubble ? inst_t'(0) : n};
        end
    endtask

    // One cycle: apply at the falling edge, check, then predict the next edge
    task automatic cyc(input logic va, input logic [RAW-1:0] rs1, input logic u1,
                       input logic [RAW-1:0] rs2, input logic u2, input logic [RAW-1:0] rd,
                       input logic rw, input logic ld, input logic redir);
        @(negedge clk);
        v_valid = va; v_rs1 = rs1; v_u1 = u1; v_rs2 = rs2; v_u2 = u2;
        v_rd = rd; v_rw = rw; v_ld = ld; v_redir = redir;
        drive();
        #1;
        check_all();
        advance_model();
    endtask

    initial begin
        h1 = '0; h2 = '0;
        v_rstn = 1'b0; v_clr = 1'b0;
`ifdef HAZARD_PERF_EN
        m_sc1 = 0; m_fe1 = 0; m_sc2 = 0; m_fe2 = 0;
`endif
        // Reset state, including a redirect and a would-be hazard held in reset
        cyc(1, 5'd7, 1, 5'd7, 1, 5'd7, 1, 1, 1);
        cyc(1, 5'd7, 1, 5'd7, 1, 5'd7, 1, 1, 0);
        v_rstn = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ALU chain: writer of x5 then readers at distance 1, 2, 3
        cyc(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
        cyc(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
        cyc(1, 5'd5, 1, 5'd9, 1, 5'd0, 0, 0, 0);
        cyc(1, 5'd5, 1, 5'd5, 1, 5'd0, 0, 0, 0);

        // Load-use: lw x7 then add x8,x7,x7 held in ID while stalled
        cyc(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0);
        repeat (3) cyc(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0);

        // x0 never matches; unused rs2 never forwards
        cyc(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0);
        cyc(1, 5'd0, 1, 5'd0, 1, 5'd2, 1, 0, 0);
        cyc(1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 0, 0);
        cyc(1, 5'd4, 0, 5'd4, 0, 5'd2, 1, 0, 0);

        // Youngest wins on back-to-back writes of x3
        cyc(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 0, 0);
        cyc(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 0, 0);
        cyc(1, 5'd3, 1, 5'd3, 1, 5'd2, 1, 0, 0);

        // Redirect coinciding with a load-use hazard, then the refetched reader
        cyc(1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1, 0);
        cyc(1, 5'd9, 1, 5'd0, 0, 5'd11, 1, 0, 1);
        cyc(1, 5'd9, 1, 5'd9, 1, 5'd12, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset dropped between edges during a stall
        cyc(1, 5'd1, 1, 5'd0, 0, 5'd10, 1, 1, 0);
        cyc(1, 5'd10, 1, 5'd0, 0, 5'd13, 1, 0, 0);
        #2;
        v_rstn = 1'b0;
        resetn = 1'b0;
        #1;
        h1 = '0; h2 = '0;
`ifdef HAZARD_PERF_EN
        m_sc1 = 0; m_fe1 = 0; m_sc2 = 0; m_fe2 = 0;
`endif
        check_all();
        advance_model();
        cyc(1, 5'd10, 1, 5'd0, 0, 5'd13, 1, 0, 0);
        v_rstn = 1'b1;

`ifdef HAZARD_PERF_EN
        // One-cycle counter clear
        cyc(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 1);
        cyc(1, 5'd6, 1, 5'd0, 0, 5'd2, 1, 0, 0);
        v_clr = 1'b1;
        cyc(1, 5'd6, 1, 5'd0, 0, 5'd2, 1, 0, 1);
        v_clr = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

        // Randomized traffic over a small register set to force collisions
        for (int i = 0; i < 400; i++) begin
            v_rstn = ($urandom % 64) != 0;
            v_clr  = ($urandom % 32) == 0;
            cyc(($urandom % 8) != 0,
                5'($urandom_range(0, 3)), 1'($urandom),
                5'($urandom_range(0, 3)), 1'($urandom),
                5'($urandom_range(0, 3)), ($urandom % 4) != 0,
                ($urandom % 3) == 0, ($urandom % 8) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound in case the run never reaches its summary
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
